// File: rtl/ram_fifo_ctrl.sv
// Ready/valid FIFO front-end for the single-port ram block, with a registered
// first-word-fall-through output stage. Optional RAM_FIFO_CTRL_STATS_EN adds HighWater.
module ram_fifo_ctrl #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 6
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         PushValid,
    output logic         PushReady,
    input  logic [N-1:0] PushData,
    output logic         PopValid,
    input  logic         PopReady,
    output logic [N-1:0] PopData,
    output logic         RamWE,
    output logic [M-1:0] RamA,
    output logic [N-1:0] RamD,
    input  logic [N-1:0] RamQ,
    output logic [M:0]   Count,
    output logic         Empty,
    output logic         Full
`ifdef RAM_FIFO_CTRL_STATS_EN
    ,
    output logic [M:0]   HighWater
`endif
);

    localparam logic [M:0] RamDepth = {1'b1, {M{1'b0}}};

    logic [M-1:0] wr_ptr_q, wr_ptr_d;
    logic [M-1:0] rd_ptr_q, rd_ptr_d;
    logic [M:0]   ram_cnt_q, ram_cnt_d;
    logic         rd_pend_q, rd_pend_d;
    logic         pop_valid_q, pop_valid_d;
    logic [N-1:0] pop_data_q, pop_data_d;

    logic pop_fire, slot_free, ram_empty, ram_full;
    logic read_ok, bypass_ok, write_ok;
    logic do_read, do_bypass, do_write;

    // Slot arbitration; readiness is decided without looking at PushValid.
    always_comb begin
        pop_fire  = pop_valid_q & PopReady;
        slot_free = ~pop_valid_q | pop_fire;
        ram_empty = (ram_cnt_q == '0);
        ram_full  = (ram_cnt_q == RamDepth);

        read_ok   = slot_free & ~rd_pend_q & ~ram_empty;
        bypass_ok = slot_free & ~rd_pend_q & ram_empty;
        // A write behind an in-flight read of the last RAM word is held off.
        write_ok  = ~ram_full & ~read_ok & ~bypass_ok & ~(rd_pend_q & ram_empty);

        do_read   = read_ok;
        do_bypass = bypass_ok & PushValid;
        do_write  = write_ok & PushValid;
    end

    always_comb begin
        PushReady = ~Reset & (bypass_ok | write_ok);
        RamWE     = do_write;
        RamA      = do_write ? wr_ptr_q : rd_ptr_q;
        RamD      = do_write ? PushData : '0;
        PopValid  = pop_valid_q;
        PopData   = pop_data_q;
        Count     = ram_cnt_q + (M+1)'(pop_valid_q) + (M+1)'(rd_pend_q);
        Empty     = (Count == '0);
        Full      = ram_full;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + M'(do_write);
        rd_ptr_d    = rd_ptr_q + M'(do_read);
        ram_cnt_d   = ram_cnt_q + (M+1)'(do_write) - (M+1)'(do_read);
        rd_pend_d   = do_read;
        pop_valid_d = pop_valid_q;
        pop_data_d  = pop_data_q;
        // The output register is always empty while a read is in flight.
        if (rd_pend_q) begin
            pop_valid_d = 1'b1;
            pop_data_d  = RamQ;
        end else if (do_bypass) begin
            pop_valid_d = 1'b1;
            pop_data_d  = PushData;
        end else if (pop_fire) begin
            pop_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            rd_pend_q   <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            rd_pend_q   <= rd_pend_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

`ifdef RAM_FIFO_CTRL_STATS_EN
    logic [M:0] high_water_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            high_water_q <= '0;
        end else if (Count > high_water_q) begin
            high_water_q <= Count;
        end
    end

    assign HighWater = high_water_q;
`endif

endmodule
